// File: rtl/issue_scoreboard_if.sv
// Decoder-to-scoreboard handshake plus the scoreboard's issue and status outputs.
// The decoder side is the master and the scoreboard is the slave.
interface issue_scoreboard_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  modport master (
    output in_valid, opcode, funct7, rd, rs1, rs2, flush,
    input  in_ready, issue_valid, issue_rd, busy_mask, stall_cycles
  );

  modport slave (
    input  in_valid, opcode, funct7, rd, rs1, rs2, flush,
    output in_ready, issue_valid, issue_rd, busy_mask, stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// RV32 register-hazard scoreboard: a per-register countdown of pending writes
// stalls RAW/WAW hazards, and a saturating counter tracks stalled cycles.
module issue_scoreboard #(
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 3,
  parameter int LAT_MUL  = 5,
  parameter int CNT_W    = 3
) (
  input logic               clk,
  input logic               rst,
  issue_scoreboard_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] next_cnt [32];
  logic [31:0]      next_busy;

  logic             uses_rs1;
  logic             uses_rs2;
  logic             writes_op;
  logic             writes_rd;
  logic [CNT_W-1:0] lat_sel;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_busy;
  logic             hazard;
  logic             do_issue;
  logic             stall_inc;

  // Which register fields the opcode actually reads and writes; unknown opcodes touch nothing.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_op = 1'b0;
    case (bus.opcode)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_op = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; writes_op = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_op = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; writes_op = 1'b1; end
      OP_LUI:    writes_op = 1'b1;
      OP_AUIPC:  writes_op = 1'b1;
      OP_JAL:    writes_op = 1'b1;
      default:   ;
    endcase
  end

  assign writes_rd = writes_op && (bus.rd != 5'd0);

  always_comb begin
    lat_sel = CNT_W'(LAT_ALU);
    if (bus.opcode == OP_R && bus.funct7 == F7_MULDIV) begin
      lat_sel = CNT_W'(LAT_MUL);
    end else if (bus.opcode == OP_LOAD) begin
      lat_sel = CNT_W'(LAT_LOAD);
    end
  end

  // x0 is excluded explicitly so it can never look busy.
  assign rs1_busy  = uses_rs1  && (bus.rs1 != 5'd0) && (cnt[bus.rs1] != '0);
  assign rs2_busy  = uses_rs2  && (bus.rs2 != 5'd0) && (cnt[bus.rs2] != '0);
  assign rd_busy   = writes_rd && (cnt[bus.rd] != '0);
  assign hazard    = rs1_busy || rs2_busy || rd_busy;

  assign bus.in_ready = !hazard && !bus.flush && !rst;
  assign do_issue     = bus.in_valid && bus.in_ready;
  assign stall_inc    = bus.in_valid && !bus.in_ready && !bus.flush;

  // WAW blocking guarantees a reloaded register is already at zero, so reload simply wins.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      next_cnt[r] = '0;
      if (do_issue && writes_rd && (bus.rd == 5'(r))) begin
        next_cnt[r] = lat_sel;
      end else if (cnt[r] != '0) begin
        next_cnt[r] = cnt[r] - CNT_W'(1);
      end
      next_busy[r] = (next_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
      bus.busy_mask    <= '0;
      bus.issue_valid  <= 1'b0;
      bus.issue_rd     <= '0;
      bus.stall_cycles <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= next_cnt[r];
      end
      bus.busy_mask   <= next_busy;
      bus.issue_valid <= do_issue;
      bus.issue_rd    <= (do_issue && writes_rd) ? bus.rd : 5'd0;
      if (stall_inc && (bus.stall_cycles != 16'hFFFF)) begin
        bus.stall_cycles <= bus.stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed, table-driven bench for issue_scoreboard: one table row per clock
// cycle, plus a hand-written sequence for reset asserted inside a stall window.
module tb_issue_scoreboard;

  logic clk;
  logic rst;

  issue_scoreboard_if sb_if ();

  issue_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] UNK  = 7'b1111111;
  localparam logic [6:0] MULF = 7'b0000001;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_ready;
    logic        exp_iv;
    logic [4:0]  exp_ird;
    logic [31:0] exp_busy;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs [24];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic v, input logic f, input logic [6:0] op,
                              input logic [6:0] f7, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic er, input logic eiv, input logic [4:0] eird,
                              input logic [31:0] eb, input logic [15:0] es);
    vec_t t;
    t.valid = v;  t.flush = f;  t.op = op;  t.f7 = f7;
    t.rd = rd;  t.rs1 = rs1;  t.rs2 = rs2;
    t.exp_ready = er;  t.exp_iv = eiv;  t.exp_ird = eird;
    t.exp_busy = eb;  t.exp_stall = es;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [6:0] op,
                       input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    sb_if.in_valid = v;
    sb_if.flush    = f;
    sb_if.opcode   = op;
    sb_if.funct7   = f7;
    sb_if.rd       = rd;
    sb_if.rs1      = rs1;
    sb_if.rs2      = rs2;
  endtask

  // Drives one cycle's inputs just after a rising edge, checks the combinational
  // ready mid-cycle, then checks the registered outputs just after the next edge.
  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    drive(v.valid, v.flush, v.op, v.f7, v.rd, v.rs1, v.rs2);
    #1;
    tag = $sformatf("vec%0d in_ready", idx);
    check_output(tag, {31'd0, sb_if.in_ready}, {31'd0, v.exp_ready});
    @(posedge clk);
    #1;
    tag = $sformatf("vec%0d issue_valid", idx);
    check_output(tag, {31'd0, sb_if.issue_valid}, {31'd0, v.exp_iv});
    if (v.exp_iv) begin
      tag = $sformatf("vec%0d issue_rd", idx);
      check_output(tag, {27'd0, sb_if.issue_rd}, {27'd0, v.exp_ird});
    end
    tag = $sformatf("vec%0d busy_mask", idx);
    check_output(tag, sb_if.busy_mask, v.exp_busy);
    tag = $sformatf("vec%0d stall_cycles", idx);
    check_output(tag, {16'd0, sb_if.stall_cycles}, {16'd0, v.exp_stall});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            v  f  op    f7    rd  rs1 rs2  rdy iv ird  busy          stall
    vecs[0]  = mk(1, 0, ADD,  7'd0, 5,  1,  2,   1,  1, 5,  32'h0000_0020, 16'd0);
    vecs[1]  = mk(0, 0, 7'd0, 7'd0, 0,  0,  0,   1,  0, 0,  32'h0000_0000, 16'd0);
    vecs[2]  = mk(1, 0, LW,   7'd0, 3,  1,  0,   1,  1, 3,  32'h0000_0008, 16'd0);
    vecs[3]  = mk(1, 0, ADD,  7'd0, 4,  3,  1,   0,  0, 0,  32'h0000_0008, 16'd1);
    vecs[4]  = mk(1, 0, ADD,  7'd0, 4,  3,  1,   0,  0, 0,  32'h0000_0008, 16'd2);
    vecs[5]  = mk(1, 0, ADD,  7'd0, 4,  3,  1,   0,  0, 0,  32'h0000_0000, 16'd3);
    vecs[6]  = mk(1, 0, ADD,  7'd0, 4,  3,  1,   1,  1, 4,  32'h0000_0010, 16'd3);
    vecs[7]  = mk(1, 0, ADD,  MULF, 6,  1,  2,   1,  1, 6,  32'h0000_0040, 16'd3);
    vecs[8]  = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   0,  0, 0,  32'h0000_0040, 16'd4);
    vecs[9]  = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   0,  0, 0,  32'h0000_0040, 16'd5);
    vecs[10] = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   0,  0, 0,  32'h0000_0040, 16'd6);
    vecs[11] = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   0,  0, 0,  32'h0000_0040, 16'd7);
    vecs[12] = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   0,  0, 0,  32'h0000_0000, 16'd8);
    vecs[13] = mk(1, 0, ADDI, 7'd0, 6,  7,  0,   1,  1, 6,  32'h0000_0040, 16'd8);
    vecs[14] = mk(1, 0, ADDI, 7'd0, 0,  0,  0,   1,  1, 0,  32'h0000_0000, 16'd8);
    vecs[15] = mk(1, 0, ADD,  7'd0, 1,  0,  0,   1,  1, 1,  32'h0000_0002, 16'd8);
    vecs[16] = mk(1, 0, LW,   7'd0, 8,  2,  0,   1,  1, 8,  32'h0000_0100, 16'd8);
    vecs[17] = mk(1, 1, SW,   7'd0, 5,  9,  8,   0,  0, 0,  32'h0000_0100, 16'd8);
    vecs[18] = mk(1, 0, SW,   7'd0, 5,  9,  8,   0,  0, 0,  32'h0000_0100, 16'd9);
    vecs[19] = mk(1, 0, SW,   7'd0, 5,  9,  8,   0,  0, 0,  32'h0000_0000, 16'd10);
    vecs[20] = mk(1, 0, SW,   7'd0, 5,  9,  8,   1,  1, 0,  32'h0000_0000, 16'd10);
    vecs[21] = mk(1, 0, ADD,  7'd0, 10, 11, 12,  1,  1, 10, 32'h0000_0400, 16'd10);
    vecs[22] = mk(1, 0, ADD,  7'd0, 11, 12, 13,  1,  1, 11, 32'h0000_0800, 16'd10);
    vecs[23] = mk(1, 0, UNK,  7'd0, 11, 11, 11,  1,  1, 0,  32'h0000_0000, 16'd10);

    drive(0, 0, 7'd0, 7'd0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset in_ready", {31'd0, sb_if.in_ready}, 32'd0);
    check_output("reset issue_valid", {31'd0, sb_if.issue_valid}, 32'd0);
    check_output("reset issue_rd", {27'd0, sb_if.issue_rd}, 32'd0);
    check_output("reset busy_mask", sb_if.busy_mask, 32'd0);
    check_output("reset stall_cycles", {16'd0, sb_if.stall_cycles}, 32'd0);
    rst = 1'b0;

    $display("[TB] applying %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      apply_stimulus(i, vecs[i]);
    end

    // Reset in the middle of a mul stall window drops the pending count.
    $display("[TB] reset during mul stall window");
    apply_stimulus(100, mk(1, 0, ADD,  MULF, 6, 1, 2, 1, 1, 6, 32'h0000_0040, 16'd10));
    apply_stimulus(101, mk(1, 0, ADDI, 7'd0, 7, 6, 0, 0, 0, 0, 32'h0000_0040, 16'd11));
    apply_stimulus(102, mk(1, 0, ADDI, 7'd0, 7, 6, 0, 0, 0, 0, 32'h0000_0040, 16'd12));
    rst = 1'b1;
    #1;
    check_output("rst mid-stall in_ready", {31'd0, sb_if.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_output("rst mid-stall busy_mask", sb_if.busy_mask, 32'd0);
    check_output("rst mid-stall issue_valid", {31'd0, sb_if.issue_valid}, 32'd0);
    check_output("rst mid-stall stall_cycles", {16'd0, sb_if.stall_cycles}, 32'd0);
    rst = 1'b0;
    apply_stimulus(103, mk(1, 0, ADDI, 7'd0, 7, 6, 0, 1, 1, 7, 32'h0000_0080, 16'd0));
    apply_stimulus(104, mk(0, 0, 7'd0, 7'd0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
